// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bundle plus the ID-stage read ports of the register file.
// The master side is the pipeline; the slave side is the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              valid_in;
    logic [DATA_W-1:0] next_pc_in;
    logic [31:0]       instruction_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] mem_data_in;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output valid_in, next_pc_in, instruction_in,
        output alu_result_in, mem_data_in, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_en, wb_addr, wb_data,
        input  retired_count
    );

    modport slave (
        input  valid_in, next_pc_in, instruction_in,
        input  alu_result_in, mem_data_in, rs_addr, rt_addr,
        output rs_data, rt_data, wb_en, wb_addr, wb_data,
        output retired_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: decodes the retiring instruction, commits it into the
// 32x32 register file, serves two bypassed read ports and counts retirements.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int CNT_W  = 32
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [CNT_W-1:0]  r_cnt;

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic              w_is_r;
    logic              w_is_lw;
    logic              w_is_imm;
    logic              w_is_jal;
    logic              w_wr;
    logic [4:0]        w_dest;
    logic [DATA_W-1:0] w_src;
    logic              w_wb_en;
    logic              w_unused;

    assign w_op     = bus.instruction_in[31:26];
    assign w_rt     = bus.instruction_in[20:16];
    assign w_rd     = bus.instruction_in[15:11];
    assign w_funct  = bus.instruction_in[5:0];
    assign w_unused = ^{bus.instruction_in[25:21], bus.instruction_in[10:6]};

    assign w_is_r   = (w_op == OP_RTYPE);
    assign w_is_lw  = (w_op == OP_LW);
    assign w_is_jal = (w_op == OP_JAL);
    assign w_is_imm = (w_op == 6'h08) || (w_op == 6'h09) ||
                      (w_op == 6'h0C) || (w_op == 6'h0D) ||
                      (w_op == 6'h0A) || (w_op == 6'h0F);

    always_comb begin
        w_wr   = 1'b0;
        w_dest = w_rt;
        w_src  = bus.alu_result_in;
        unique case (1'b1)
            w_is_r: begin
                w_wr   = (w_funct != FN_JR);
                w_dest = w_rd;
            end
            w_is_lw: begin
                w_wr  = 1'b1;
                w_src = bus.mem_data_in;
            end
            w_is_imm: w_wr = 1'b1;
            w_is_jal: begin
                w_wr   = 1'b1;
                w_dest = 5'd31;
                w_src  = bus.next_pc_in;
            end
            default: w_wr = 1'b0;
        endcase
    end

    // r0 is hardwired: a write to it is never enabled
    assign w_wb_en = bus.valid_in & w_wr & (w_dest != 5'd0);

    assign bus.wb_en         = w_wb_en;
    assign bus.wb_addr       = w_dest;
    assign bus.wb_data       = w_src;
    assign bus.retired_count = r_cnt;

    assign bus.rs_data =
        (bus.rs_addr == 5'd0)                   ? '0    :
        (w_wb_en && (w_dest == bus.rs_addr))    ? w_src :
                                                  r_regs[bus.rs_addr];

    assign bus.rt_data =
        (bus.rt_addr == 5'd0)                   ? '0    :
        (w_wb_en && (w_dest == bus.rt_addr))    ? w_src :
                                                  r_regs[bus.rt_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            if (w_wb_en) begin
                r_regs[w_dest] <= w_src;
            end
            if (bus.valid_in) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared against an array-based architectural model.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wb_regfile_if #(.DATA_W(32), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

    wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    function automatic logic [31:0] mk(int op, int rs, int rt, int rd, int fn);
        logic [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
        return w;
    endfunction

    // Architectural meaning of one retiring instruction
    function automatic void ref_wb(input logic [31:0] ins, input logic [31:0] alu,
                                   input logic [31:0] mem, input logic [31:0] npc,
                                   output bit wr, output int dst, output logic [31:0] val);
        int op;
        op  = int'(ins[31:26]);
        wr  = 0;
        dst = 0;
        val = 32'h0;
        if (op == 0 && ins[5:0] != 6'h08) begin
            wr = 1; dst = int'(ins[15:11]); val = alu;
        end else if (op == 'h23) begin
            wr = 1; dst = int'(ins[20:16]); val = mem;
        end else if (op inside {'h08, 'h09, 'h0C, 'h0D, 'h0A, 'h0F}) begin
            wr = 1; dst = int'(ins[20:16]); val = alu;
        end else if (op == 'h03) begin
            wr = 1; dst = 31; val = npc;
        end
        if (dst == 0) wr = 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        bit wr;
        int dst;
        logic [31:0] val;
        ref_wb(bus.instruction_in, bus.alu_result_in, bus.mem_data_in,
               bus.next_pc_in, wr, dst, val);
        if (a == 5'd0) return 32'h0;
        if (bus.valid_in && wr && dst == int'(a)) return val;
        return m_regs[a];
    endfunction

    function automatic bit exp_en();
        bit wr;
        int dst;
        logic [31:0] val;
        ref_wb(bus.instruction_in, bus.alu_result_in, bus.mem_data_in,
               bus.next_pc_in, wr, dst, val);
        return bus.valid_in && wr;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] npc, input logic [4:0] ra,
                         input logic [4:0] rb);
        bus.valid_in       = v;
        bus.instruction_in = ins;
        bus.alu_result_in  = alu;
        bus.mem_data_in    = mem;
        bus.next_pc_in     = npc;
        bus.rs_addr        = ra;
        bus.rt_addr        = rb;
    endtask

    task automatic bubble(input logic [4:0] ra, input logic [4:0] rb);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ra, rb);
    endtask

    task automatic commit();
        bit wr;
        int dst;
        logic [31:0] val;
        ref_wb(bus.instruction_in, bus.alu_result_in, bus.mem_data_in,
               bus.next_pc_in, wr, dst, val);
        @(posedge clk);
        #1;
        if (bus.valid_in) begin
            m_cnt = m_cnt + 1;
            if (wr) m_regs[dst] = val;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
    endtask

    task automatic test_reset();
        bubble(5'd5, 5'd31);
        bus4.valid_in = 1'b0; bus4.instruction_in = 32'h0;
        bus4.alu_result_in = 32'h0; bus4.mem_data_in = 32'h0;
        bus4.next_pc_in = 32'h0; bus4.rs_addr = 5'd0; bus4.rt_addr = 5'd0;
        model_clear();
        #2;
        checks++;
        if (bus.retired_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0", bus.retired_count);
        end
        checks++;
        if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd got %h/%h want 0", bus.rs_data, bus.rt_data);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rtype();
        drive(1'b1, 32'h00221820, 32'hDEADBEEF, $urandom, $urandom, 5'd1, 5'd2);
        #1;
        checks++;
        if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd3 || bus.wb_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rtype_wb got en=%b a=%0d d=%h want 1/3/deadbeef",
                     bus.wb_en, bus.wb_addr, bus.wb_data);
        end
        commit();
        bubble(5'd3, 5'd0);
        #1;
        checks++;
        if (bus.rs_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rtype_rd got %h want deadbeef", bus.rs_data);
        end
        checks++;
        if (bus.retired_count !== 32'd1) begin
            errors++;
            $display("FAIL rtype_cnt got %0d want 1", bus.retired_count);
        end
    endtask

    task automatic test_load_bypass();
        drive(1'b1, mk('h23, 4, 7, 0, 0), $urandom, 32'hCAFEF00D, $urandom, 5'd7, 5'd7);
        #1;
        checks++;
        if (bus.rs_data !== 32'hCAFEF00D || bus.rt_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL lw_bypass got %h/%h want cafef00d", bus.rs_data, bus.rt_data);
        end
        commit();
        bubble(5'd7, 5'd3);
        #1;
        checks++;
        if (bus.rs_data !== 32'hCAFEF00D || bus.rt_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_commit got %h/%h want cafef00d/deadbeef",
                     bus.rs_data, bus.rt_data);
        end
    endtask

    task automatic test_jal_r0();
        drive(1'b1, 32'h0C100006, $urandom, $urandom, 32'h00400018, 5'd0, 5'd0);
        commit();
        bubble(5'd31, 5'd0);
        #1;
        checks++;
        if (bus.rs_data !== 32'h00400018) begin
            errors++;
            $display("FAIL jal got %h want 00400018", bus.rs_data);
        end
        drive(1'b1, mk('h08, 3, 0, 0, 0), 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        checks++;
        if (bus.wb_en !== 1'b0 || bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_guard got en=%b rd=%h want 0/0", bus.wb_en, bus.rs_data);
        end
        commit();
        bubble(5'd0, 5'd0);
        #1;
        checks++;
        if (bus.rt_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_after got %h want 0", bus.rt_data);
        end
    endtask

    task automatic test_nowrite();
        logic [31:0] snap [32];
        logic [31:0] ins [4];
        logic [31:0] c0;
        for (int i = 0; i < 32; i++) snap[i] = m_regs[i];
        c0 = m_cnt;
        ins[0] = mk('h2B, 1, 9, 10, 2);
        ins[1] = mk('h04, 1, 2, 11, 3);
        ins[2] = mk(0, 31, 0, 0, 8);
        ins[3] = mk(0, 1, 2, 12, 'h20);
        for (int k = 0; k < 4; k++) begin
            drive(k != 3, ins[k], $urandom, $urandom, $urandom, 5'd0, 5'd0);
            #1;
            checks++;
            if (bus.wb_en !== 1'b0) begin
                errors++;
                $display("FAIL nowrite_en%0d got %b want 0", k, bus.wb_en);
            end
            commit();
        end
        checks++;
        if (bus.retired_count !== c0 + 32'd3) begin
            errors++;
            $display("FAIL nowrite_cnt got %0d want %0d", bus.retired_count, c0 + 3);
        end
        for (int i = 0; i < 32; i++) begin
            bubble(5'(i), 5'(31 - i));
            #1;
            checks++;
            if (bus.rs_data !== snap[i] || bus.rt_data !== snap[31 - i]) begin
                errors++;
                $display("FAIL nowrite_reg%0d got %h/%h want %h/%h", i,
                         bus.rs_data, bus.rt_data, snap[i], snap[31 - i]);
            end
        end
    endtask

    task automatic test_random();
        int ops [14] = '{'h00, 'h23, 'h08, 'h09, 'h0C, 'h0D, 'h0A,
                         'h0F, 'h03, 'h2B, 'h04, 'h05, 'h02, 'h3F};
        logic [31:0] ins;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        bit e_en;
        for (int n = 0; n < 300; n++) begin
            ins = mk(ops[$urandom_range(13)], $urandom_range(31), $urandom_range(31),
                     $urandom_range(31),
                     ($urandom_range(3) == 0) ? 8 : $urandom_range(63));
            drive($urandom_range(3) != 0, ins, $urandom, $urandom, $urandom,
                  5'($urandom_range(31)), 5'($urandom_range(31)));
            #1;
            e_rs = exp_rd(bus.rs_addr);
            e_rt = exp_rd(bus.rt_addr);
            e_en = exp_en();
            checks++;
            if (bus.rs_data !== e_rs || bus.rt_data !== e_rt || bus.wb_en !== e_en) begin
                errors++;
                $display("FAIL rand%0d got rs=%h rt=%h en=%b want %h %h %b", n,
                         bus.rs_data, bus.rt_data, bus.wb_en, e_rs, e_rt, e_en);
            end
            commit();
            checks++;
            if (bus.retired_count !== m_cnt) begin
                errors++;
                $display("FAIL rand_cnt%0d got %0d want %0d", n, bus.retired_count, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, mk('h08, 0, 5, 0, 0), 32'h1234, 32'h0, 32'h0, 5'd5, 5'd0);
        commit();
        bubble(5'd5, 5'd0);
        #1;
        checks++;
        if (bus.rs_data !== 32'h1234) begin
            errors++;
            $display("FAIL rst_pre got %h want 1234", bus.rs_data);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.rs_data !== 32'h0 || bus.retired_count !== 32'h0) begin
            errors++;
            $display("FAIL rst_async got %h/%0d want 0/0", bus.rs_data, bus.retired_count);
        end
        model_clear();
        drive(1'b1, mk('h08, 0, 6, 0, 0), 32'h5A5A5A5A, 32'h0, 32'h0, 5'd0, 5'd6);
        #1;
        checks++;
        if (bus.rt_data !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL rst_bypass got %h want 5a5a5a5a", bus.rt_data);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        bubble(5'd6, 5'd5);
        #1;
        checks++;
        if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0 || bus.retired_count !== 32'h0) begin
            errors++;
            $display("FAIL rst_lost got %h/%h/%0d want 0/0/0",
                     bus.rs_data, bus.rt_data, bus.retired_count);
        end
        drive(1'b1, mk('h08, 0, 6, 0, 0), 32'h77, 32'h0, 32'h0, 5'd0, 5'd0);
        commit();
        bubble(5'd6, 5'd0);
        #1;
        checks++;
        if (bus.rs_data !== 32'h77 || bus.retired_count !== 32'd1) begin
            errors++;
            $display("FAIL rst_release got %h/%0d want 77/1", bus.rs_data, bus.retired_count);
        end
    endtask

    task automatic test_wrap();
        bus4.valid_in = 1'b1;
        bus4.instruction_in = mk('h2B, 1, 2, 0, 0);
        for (int n = 1; n <= 17; n++) begin
            @(posedge clk);
            #1;
            if (n == 16) begin
                checks++;
                if (bus4.retired_count !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap16 got %0d want 0", bus4.retired_count);
                end
            end
        end
        bus4.valid_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus4.retired_count !== 4'd1) begin
            errors++;
            $display("FAIL wrap17 got %0d want 1", bus4.retired_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_load_bypass();
        test_jal_r0();
        test_nowrite();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface.
- Consumes the MEM/WB pipeline register outputs (next_pc, instruction), plus the ALU result, load data and a valid bit from the same stage.
- Decodes the write-back destination and source, and commits into a 32x32 architectural register file.
- Provides two bypassed read ports to ID and a retired-instruction counter.

Parameters:
- DATA_W, 32, register and datapath width
- NREGS, 32, number of architectural registers (address width = 5)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-low
- valid_in  input  1  MEM/WB slot holds a real instruction (0 = bubble)
- next_pc_in  input  DATA_W  PC+4 of the instruction in WB
- instruction_in  input  32  instruction word in WB
- alu_result_in  input  DATA_W  ALU result carried to WB
- mem_data_in  input  DATA_W  load data carried to WB
- rs_addr  input  5  read port 1 address (ID stage)
- rt_addr  input  5  read port 2 address (ID stage)
- rs_data  output  DATA_W  read port 1 data
- rt_data  output  DATA_W  read port 2 data
- wb_en  output  1  write-back occurs this cycle (for forwarding unit)
- wb_addr  output  5  destination register this cycle
- wb_data  output  DATA_W  value written this cycle
- retired_count  output  CNT_W  number of valid instructions retired

Behaviour:
- Decode (combinational from instruction_in). op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
  - op 0x00, funct != 0x08: dest = rd, src = alu_result_in.
  - op 0x00, funct 0x08 (jr): no write.
  - op 0x23 (lw): dest = rt, src = mem_data_in.
  - op 0x08 / 0x09 / 0x0C / 0x0D / 0x0A / 0x0F (addi / addiu / andi / ori / slti / lui): dest = rt, src = alu_result_in.
  - op 0x03 (jal): dest = 31, src = next_pc_in.
  - All other opcodes (sw, beq, bne, j, unknown): no write.
- wb_en = valid_in & write-class & (dest != 0). wb_addr and wb_data are driven from the decode even when wb_en = 0 (don't-care for consumers). All 0x00000000 instruction (sll r0) yields wb_en = 0.
- Commit: on a rising clk edge with wb_en = 1, regs[wb_addr] <= wb_data. Latency is one edge; the value is visible in regs on the following cycle.
- Register 0 is never written and always reads 0.
- Reads are combinational.
  - rs_data = 0 if rs_addr = 0.
  - Otherwise, if wb_en and wb_addr == rs_addr, rs_data = wb_data (same-cycle write-through bypass).
  - Otherwise, rs_data = regs[rs_addr].
  - rt_data follows the same rule with rt_addr. Both ports may hit the bypass simultaneously.
- retired_count increments by 1 on every rising edge with valid_in = 1, including non-writing instructions. It wraps modulo 2^CNT_W with no saturation.
- Reset: rst low asynchronously clears all regs to 0 and retired_count to 0.
  - rs_data and rt_data then read 0 unless the bypass is active.
  - A write coinciding with reset assertion is lost.
  - On release, the first rising edge with rst high performs normal commit.
- Bubble (valid_in = 0): no write and no count increment, regardless of instruction_in contents.

Test Plan:
- Reset: pulse rst low mid-run after writing r5 = 0x1234 -> r5 reads 0 and retired_count = 0 immediately, with no clk edge needed.
- R-type: valid_in = 1, instruction = add r3,r1,r2 (0x00221820), alu_result = 0xDEADBEEF -> wb_en = 1, wb_addr = 3; next cycle rs_addr = 3 reads 0xDEADBEEF; retired_count = 1.
- Load and bypass: lw r7 (op 0x23, rt = 7), mem_data = 0xCAFEF00D, with rs_addr = rt_addr = 7 in the same cycle -> both ports return 0xCAFEF00D before the edge.
- jal / r0 guard: jal -> r31 = next_pc_in (0x00400018). Then addi with rt = 0, alu_result = 0xFFFFFFFF -> wb_en = 0 and r0 reads 0.
- No-write classes: sw, beq, jr r31, and a bubble with an add instruction -> no register changes; retired_count increases by 3 (bubble not counted).
- Wrap: CNT_W = 4; retire 17 valid instructions -> retired_count = 1.
